qbert_move_ctrl: RTL and testbench

Jump-command initiator for the Q*bert sprite layer. Samples the player direction buttons, computes Q*bert's next cube on the 28-cube pyramid, flags jumps that leave the pyramid, and drives the jump handshake toward `qbert_layer` by issuing a command and tracking `done_move`. It sits between the Nios button/PIO registers and `qbert_layer`, and is the single owner of `position_qb`, `e_next_qb`, `e_jump_qb` and `e_bad_jump`.

---
 rtl/qbert_pkg.sv | 55 +++++
 rtl/qbert_next_cube.sv | 55 +++++
 rtl/qbert_move_ctrl.sv | 172 +++++++++++++++++
 tb/tb_qbert_move_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qbert_pkg.sv
// Shared Q*bert sprite-layer types: jump codes, move-controller states and
// one-hot pyramid edge constants (cube k lives in bit k-1).
package qbert_pkg;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    DR   = 3'd1,
    DL   = 3'd2,
    UR   = 3'd3,
    UL   = 3'd4
  } jump_t;

  typedef enum logic [1:0] {
    MS_IDLE    = 2'd0,
    MS_ISSUE   = 2'd1,
    MS_MOVING  = 2'd2,
    MS_KO_WAIT = 2'd3
  } mctrl_state_t;

  localparam logic [27:0] TOP = 28'h000_0001;
  localparam logic [27:0] R02 = 28'h000_0002;
  localparam logic [27:0] R04 = 28'h000_0008;
  localparam logic [27:0] R07 = 28'h000_0040;
  localparam logic [27:0] R11 = 28'h000_0400;
  localparam logic [27:0] R16 = 28'h000_8000;
  localparam logic [27:0] R22 = 28'h020_0000;
  localparam logic [27:0] L03 = 28'h000_0004;
  localparam logic [27:0] L06 = 28'h000_0020;
  localparam logic [27:0] L10 = 28'h000_0200;
  localparam logic [27:0] L15 = 28'h000_4000;
  localparam logic [27:0] L21 = 28'h010_0000;
  localparam logic [27:0] L28 = 28'h800_0000;

  // Column-1 edge, column-r edge and bottom row (cubes 22..28).
  localparam logic [27:0] R_EDGE = TOP | R02 | R04 | R07 | R11 | R16 | R22;
  localparam logic [27:0] L_EDGE = TOP | L03 | L06 | L10 | L15 | L21 | L28;
  localparam logic [27:0] ROW7   = 28'hFE0_0000;

  function automatic jump_t btn_to_jump(input logic [3:0] b);
    jump_t j;
    if (b[0]) begin
      j = DR;
    end else if (b[1]) begin
      j = DL;
    end else if (b[2]) begin
      j = UR;
    end else if (b[3]) begin
      j = UL;
    end else begin
      j = NONE;
    end
    return j;
  endfunction

endpackage

// File: rtl/qbert_next_cube.sv
// Combinational pyramid geometry: one-hot cube plus jump code to the one-hot
// target cube, with an off flag when the jump leaves the pyramid.
module qbert_next_cube
  import qbert_pkg::*;
(
  input  logic [27:0] pos,
  input  jump_t       jump,
  output logic [27:0] next_cube,
  output logic        off
);

  function automatic logic [27:0] target_bit(input int r, input int c, input jump_t j);
    int tr;
    int tc;
    logic [27:0] res;
    case (j)
      DR:      begin tr = r + 1; tc = c;     end
      DL:      begin tr = r + 1; tc = c + 1; end
      UR:      begin tr = r - 1; tc = c - 1; end
      UL:      begin tr = r - 1; tc = c;     end
      default: begin tr = 0;     tc = 0;     end
    endcase
    if (tr >= 1 && tr <= 7 && tc >= 1 && tc <= tr) begin
      res = 28'd1 << (tr * (tr - 1) / 2 + tc - 1);
    end else begin
      res = 28'd0;
    end
    return res;
  endfunction

  // Walk every (row, column) cell and OR in the target of the occupied one.
  always_comb begin
    next_cube = 28'd0;
    for (int r = 1; r <= 7; r++) begin
      for (int c = 1; c <= r; c++) begin
        if (|(pos & (28'd1 << (r * (r - 1) / 2 + c - 1)))) begin
          next_cube = next_cube | target_bit(r, c, jump);
        end else begin
          next_cube = next_cube;
        end
      end
    end
  end

  // A jump leaves the pyramid exactly when it starts on the matching edge.
  always_comb begin
    case (jump)
      DR, DL:  off = |(pos & ROW7);
      UR:      off = |(pos & R_EDGE);
      UL:      off = |(pos & L_EDGE);
      default: off = 1'b0;
    endcase
  end

endmodule

// File: rtl/qbert_move_ctrl.sv
// Q*bert jump-command initiator: button sampling, target computation and the
// done_move handshake toward qbert_layer. Option macro: QBERT_AUTOREPEAT_EN.
module qbert_move_ctrl
  import qbert_pkg::*;
#(
  parameter int          N_cube  = 28,
  parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        btn,
  input  logic              e_start_qb,
  input  logic              e_pause_qb,
  input  logic              done_move,
  input  logic [3:0]        KO_qb,
  output logic [N_cube-1:0] position_qb,
  output logic [N_cube-1:0] e_next_qb,
  output logic [2:0]        e_jump_qb,
  output logic              e_bad_jump,
  output logic [N_cube-1:0] visited,
  output logic              level_done,
  output logic              ctrl_err,
  output logic [15:0]       jump_cnt
);

  localparam logic [1:0] ST_IDLE    = MS_IDLE;
  localparam logic [1:0] ST_ISSUE   = MS_ISSUE;
  localparam logic [1:0] ST_MOVING  = MS_MOVING;
  localparam logic [1:0] ST_KO_WAIT = MS_KO_WAIT;

  logic [3:0]        btn_q_r;
  logic [1:0]        state_r;
  logic [31:0]       wd_r;
  logic [3:0]        ko_ref_r;
  logic [N_cube-1:0] pos_r;
  logic [N_cube-1:0] next_r;
  logic [N_cube-1:0] visited_r;
  jump_t             jump_r;
  logic              bad_r;
  logic              err_r;
  logic [15:0]       cnt_r;
  logic              armed_s;
  logic              issue_s;
  jump_t             req_jump_s;
  logic [N_cube-1:0] tgt_s;
  logic              off_s;

  assign req_jump_s = btn_to_jump(btn_q_r);

  qbert_next_cube u_next_cube (
    .pos       (pos_r),
    .jump      (req_jump_s),
    .next_cube (tgt_s),
    .off       (off_s)
  );

  assign issue_s = (state_r == ST_IDLE) && (btn_q_r != 4'd0) && !e_pause_qb
                   && done_move && armed_s;

`ifdef QBERT_AUTOREPEAT_EN
  assign armed_s = 1'b1;
`else
  logic armed_r;

  // One jump per press: disarm on issue, re-arm once the buttons read released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_r <= 1'b1;
    end else if (e_start_qb) begin
      armed_r <= 1'b1;
    end else if (btn_q_r == 4'd0) begin
      armed_r <= 1'b1;
    end else if (issue_s) begin
      armed_r <= 1'b0;
    end else begin
      armed_r <= armed_r;
    end
  end

  assign armed_s = armed_r;
`endif

  // Button sampling plus the issue / handshake / KO state machine.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q_r   <= 4'd0;
      state_r   <= ST_IDLE;
      wd_r      <= 32'd0;
      ko_ref_r  <= 4'd0;
      pos_r     <= TOP;
      next_r    <= 28'd0;
      visited_r <= TOP;
      jump_r    <= NONE;
      bad_r     <= 1'b0;
      err_r     <= 1'b0;
      cnt_r     <= 16'd0;
    end else if (e_start_qb) begin
      btn_q_r   <= 4'd0;
      state_r   <= ST_IDLE;
      wd_r      <= 32'd0;
      ko_ref_r  <= 4'd0;
      pos_r     <= TOP;
      next_r    <= 28'd0;
      visited_r <= TOP;
      jump_r    <= NONE;
      bad_r     <= 1'b0;
      err_r     <= 1'b0;
      cnt_r     <= 16'd0;
    end else begin
      btn_q_r <= btn;
      case (state_r)
        ST_IDLE: begin
          if (issue_s) begin
            jump_r  <= req_jump_s;
            next_r  <= tgt_s;
            bad_r   <= off_s;
            wd_r    <= 32'd0;
            state_r <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!done_move) begin
            state_r <= ST_MOVING;
          end else if (wd_r == TIMEOUT - 32'd1) begin
            err_r   <= 1'b1;
            jump_r  <= NONE;
            bad_r   <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            wd_r <= wd_r + 32'd1;
          end
        end
        ST_MOVING: begin
          if (done_move) begin
            cnt_r  <= cnt_r + 16'd1;
            jump_r <= NONE;
            if (!bad_r) begin
              pos_r     <= next_r;
              visited_r <= visited_r | next_r;
              state_r   <= ST_IDLE;
            end else begin
              ko_ref_r <= KO_qb;
              state_r  <= ST_KO_WAIT;
            end
          end
        end
        ST_KO_WAIT: begin
          // Respawn only once qbert_layer has counted the fall.
          if (KO_qb != ko_ref_r) begin
            pos_r   <= TOP;
            bad_r   <= 1'b0;
            next_r  <= 28'd0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign position_qb = pos_r;
  assign e_next_qb   = next_r;
  assign e_jump_qb   = jump_r;
  assign e_bad_jump  = bad_r;
  assign visited     = visited_r;
  assign level_done  = &visited_r;
  assign ctrl_err    = err_r;
  assign jump_cnt    = cnt_r;

endmodule

// File: tb/tb_qbert_move_ctrl.sv
// Self-checking bench for qbert_move_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a row/column pyramid model.
module tb_qbert_move_ctrl;

  localparam int TMO = 40;
`ifdef QBERT_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  btn;
  logic        e_start_qb;
  logic        e_pause_qb;
  logic        done_move;
  logic [3:0]  KO_qb;
  logic [27:0] position_qb;
  logic [27:0] e_next_qb;
  logic [2:0]  e_jump_qb;
  logic        e_bad_jump;
  logic [27:0] visited;
  logic        level_done;
  logic        ctrl_err;
  logic [15:0] jump_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  qbert_move_ctrl #(.N_cube(28), .TIMEOUT(32'(TMO))) dut (
    .clk(clk), .reset(reset), .btn(btn), .e_start_qb(e_start_qb),
    .e_pause_qb(e_pause_qb), .done_move(done_move), .KO_qb(KO_qb),
    .position_qb(position_qb), .e_next_qb(e_next_qb), .e_jump_qb(e_jump_qb),
    .e_bad_jump(e_bad_jump), .visited(visited), .level_done(level_done),
    .ctrl_err(ctrl_err), .jump_cnt(jump_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model (cube indices 1..28, 0 = off) --------
  int         m_phase;   // 0 waiting for press, 1 awaiting ack, 2 in flight, 3 fallen
  int         m_pos;
  int         m_next;
  int         m_jump;
  int         m_wait;
  int         m_cnt;
  bit         m_bad;
  bit         m_err;
  bit         m_armed;
  logic [3:0] m_btnq;
  logic [3:0] m_koref;
  bit         m_vis [1:28];

  function automatic int prio(input logic [3:0] b);
    if (b[0]) return 1;
    if (b[1]) return 2;
    if (b[2]) return 3;
    if (b[3]) return 4;
    return 0;
  endfunction

  function automatic int target(input int k, input int j);
    int r, c, tr, tc;
    r = 1;
    while (r * (r + 1) / 2 < k) r++;
    c = k - r * (r - 1) / 2;
    case (j)
      1: begin tr = r + 1; tc = c;     end
      2: begin tr = r + 1; tc = c + 1; end
      3: begin tr = r - 1; tc = c - 1; end
      4: begin tr = r - 1; tc = c;     end
      default: begin tr = 0; tc = 0; end
    endcase
    if (tr < 1 || tr > 7 || tc < 1 || tc > tr) return 0;
    return tr * (tr - 1) / 2 + tc;
  endfunction

  function automatic logic [27:0] oh(input int k);
    if (k < 1) return 28'd0;
    return 28'd1 << (k - 1);
  endfunction

  function automatic logic [27:0] vis_vec();
    logic [27:0] v;
    v = 28'd0;
    for (int i = 1; i <= 28; i++) if (m_vis[i]) v = v | oh(i);
    return v;
  endfunction

  function automatic bit all_vis();
    for (int i = 1; i <= 28; i++) if (!m_vis[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    m_phase <= 0; m_pos <= 1; m_next <= 0; m_jump <= 0; m_wait <= 0;
    m_cnt <= 0; m_bad <= 1'b0; m_err <= 1'b0; m_armed <= 1'b1;
    m_btnq <= 4'd0; m_koref <= 4'd0;
    for (int i = 1; i <= 28; i++) m_vis[i] <= (i == 1);
  endtask

  always @(posedge clk or negedge reset) begin : model_b
    int tg;
    bit go;
    if (!reset) begin
      model_clear();
    end else if (e_start_qb) begin
      model_clear();
    end else begin
      go = (m_phase == 0) && (m_btnq != 4'd0) && !e_pause_qb && done_move && (AUTO || m_armed);
      if (m_btnq == 4'd0) m_armed <= 1'b1;
      else if (go) m_armed <= 1'b0;
      case (m_phase)
        0: if (go) begin
          tg = target(m_pos, prio(m_btnq));
          m_jump <= prio(m_btnq); m_next <= tg; m_bad <= (tg == 0);
          m_wait <= 0; m_phase <= 1;
        end
        1: if (!done_move) m_phase <= 2;
           else if (m_wait + 1 == TMO) begin
             m_err <= 1'b1; m_jump <= 0; m_bad <= 1'b0; m_phase <= 0;
           end else m_wait <= m_wait + 1;
        2: if (done_move) begin
          m_cnt <= (m_cnt + 1) % 65536;
          m_jump <= 0;
          if (!m_bad) begin
            m_pos <= m_next; m_vis[m_next] <= 1'b1; m_phase <= 0;
          end else begin
            m_koref <= KO_qb; m_phase <= 3;
          end
        end
        3: if (KO_qb != m_koref) begin
          m_pos <= 1; m_bad <= 1'b0; m_next <= 0; m_phase <= 0;
        end
        default: m_phase <= 0;
      endcase
      m_btnq <= btn;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset) begin
      chk("position_qb", 32'(position_qb), 32'(oh(m_pos)));
      chk("e_next_qb",   32'(e_next_qb),   32'(oh(m_next)));
      chk("e_jump_qb",   32'(e_jump_qb),   32'(m_jump));
      chk("e_bad_jump",  32'(e_bad_jump),  32'(m_bad));
      chk("visited",     32'(visited),     32'(vis_vec()));
      chk("level_done",  32'(level_done),  32'(all_vis()));
      chk("ctrl_err",    32'(ctrl_err),    32'(m_err));
      chk("jump_cnt",    32'(jump_cnt),    32'(m_cnt));
      if (e_jump_qb != 3'd0) chk("next_ne_pos", 32'(e_next_qb != position_qb), 32'd1);
    end
  end

  // ---------------- stimulus -----------------------------------------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] b);
    btn = b; tick(); tick(); btn = 4'd0; tick();
  endtask

  task automatic handshake();
    done_move = 1'b0; tick(); done_move = 1'b1; tick();
  endtask

  task automatic soft_clear();
    e_start_qb = 1'b1; tick(); e_start_qb = 1'b0; tick();
  endtask

  initial begin
    reset = 1'b0; btn = 4'd0; e_start_qb = 1'b0; e_pause_qb = 1'b0;
    done_move = 1'b1; KO_qb = 4'd0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("rst position", 32'(position_qb), 32'h1);
    chk("rst visited",  32'(visited),     32'h1);
    chk("rst jump_cnt", 32'(jump_cnt),    32'd0);
    chk("rst level",    32'(level_done),  32'd0);

    // DR from TOP lands on cube 2.
    press(4'b0001);
    chk("dr e_jump", 32'(e_jump_qb), 32'd1);
    chk("dr e_next", 32'(e_next_qb), 32'h2);
    chk("dr bad",    32'(e_bad_jump), 32'd0);
    handshake();
    chk("dr position", 32'(position_qb), 32'h2);
    chk("dr visited",  32'(visited),     32'h3);
    chk("dr cnt",      32'(jump_cnt),    32'd1);

    // UR from TOP falls off, respawns on KO change.
    soft_clear();
    press(4'b0100);
    chk("ur e_jump", 32'(e_jump_qb), 32'd3);
    chk("ur e_next", 32'(e_next_qb), 32'h0);
    chk("ur bad",    32'(e_bad_jump), 32'd1);
    handshake();
    chk("ko wait bad", 32'(e_bad_jump), 32'd1);
    chk("ko wait cnt", 32'(jump_cnt),   32'd1);
    KO_qb = KO_qb + 4'd1; tick();
    chk("ko position", 32'(position_qb), 32'h1);
    chk("ko bad",      32'(e_bad_jump),  32'd0);

    // Held button through a full handshake.
    soft_clear();
    btn = 4'b0001; tick(); tick();
    handshake();
    tick();
    chk("hold rejump", 32'(e_jump_qb), AUTO ? 32'd1 : 32'd0);
    repeat (3) tick();
    chk("hold cnt", 32'(jump_cnt), 32'd1);
    btn = 4'd0;
    soft_clear();

    // Watchdog with done_move stuck high.
    press(4'b0001);
    repeat (TMO) tick();
    chk("wd err",  32'(ctrl_err),  32'd1);
    chk("wd jump", 32'(e_jump_qb), 32'd0);
    press(4'b0010);
    chk("wd idle reissue", 32'(e_jump_qb), 32'd2);
    soft_clear();

    // Down to cube 28, bad DL, then start wins over the landing edge.
    repeat (6) begin press(4'b0010); handshake(); end
    chk("c28 position", 32'(position_qb), 32'h800_0000);
    press(4'b0010);
    chk("c28 bad", 32'(e_bad_jump), 32'd1);
    done_move = 1'b0; tick();
    done_move = 1'b1; e_start_qb = 1'b1; tick();
    e_start_qb = 1'b0;
    chk("start position", 32'(position_qb), 32'h1);
    chk("start visited",  32'(visited),     32'h1);
    chk("start next",     32'(e_next_qb),   32'h0);
    chk("start bad",      32'(e_bad_jump),  32'd0);
    chk("start cnt",      32'(jump_cnt),    32'd0);

    // Cover every cube: DL^(c-1) DR^(7-c) from TOP, fall back via bad DR.
    for (int c = 1; c <= 7; c++) begin
      for (int j = 0; j < 6; j++) begin
        if (c == 7 && j == 5) chk("pre level_done", 32'(level_done), 32'd0);
        press((j < c - 1) ? 4'b0010 : 4'b0001);
        handshake();
      end
      if (c == 7) begin
        chk("level_done", 32'(level_done), 32'd1);
      end else begin
        press(4'b0001); handshake();
        KO_qb = KO_qb + 4'd1; tick();
      end
    end
    soft_clear();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      btn        = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      done_move  = ($urandom_range(0, 3) != 0);
      e_pause_qb = ($urandom_range(0, 9) == 0);
      e_start_qb = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) KO_qb = KO_qb + 4'd1;
      tick();
    end
    e_start_qb = 1'b0; e_pause_qb = 1'b0; btn = 4'd0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
